// File: rtl/yutorina_div_ctrl_pkg.sv
// Shared types and constants for the radix-2 restoring divide sequencer.
package yutorina_div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Iteration counter width; holds WIDTH-1 down to 0.
  function automatic int div_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/yutorina_div_ctrl_if.sv
// Request/result bundle between ID/EX and the divide sequencer.
interface yutorina_div_ctrl_if import yutorina_div_ctrl_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             sign_;    // active-low: 0 selects a signed divide
  logic             sel_rem;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             dz;

  modport master (
    output start, sign_, sel_rem, lhs, rhs, flush,
    input  busy, stall, done, out, dz
  );

  modport slave (
    input  start, sign_, sel_rem, lhs, rhs, flush,
    output busy, stall, done, out, dz
  );
endinterface

// File: rtl/yutorina_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference or restore.
module yutorina_div_step import yutorina_div_ctrl_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract in WIDTH+1 bits so the borrow lands in the top bit.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/yutorina_div_ctrl.sv
// Multi-cycle DIV/MOD sequencer next to the EX ALU. Stalls the pipeline
// while a radix-2 restoring divide runs, then presents the signed/unsigned
// quotient or remainder with a one-cycle done pulse.
//
// state    | meaning
// DIV_IDLE | waiting for start; divide-by-zero jumps straight to DONE
// DIV_RUN  | one quotient bit per cycle, counter WIDTH-1 down to 0
// DIV_DONE | done/out/dz presented for one cycle, then back to IDLE
module yutorina_div_ctrl import yutorina_div_ctrl_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  yutorina_div_ctrl_if.slave  div_bus
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sel_rem_q, sel_rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             signed_en;
  logic [WIDTH-1:0] lhs_abs;
  logic [WIDTH-1:0] rhs_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_next;

  yutorina_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .bit_i   (dvd_q[WIDTH-1]),
    .dvs_i   (dvs_q),
    .rem_o   (step_rem),
    .q_bit_o (step_qbit)
  );

  assign q_next = {dvd_q[WIDTH-2:0], step_qbit};

  // Next-state, datapath and result logic; flush overrides everything last.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sel_rem_d = sel_rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    out_d     = out_q;
    dz_d      = dz_q;

    accept    = (state_q == DIV_IDLE) && div_bus.start && !div_bus.flush;
    signed_en = !div_bus.sign_;
    lhs_abs   = (signed_en && div_bus.lhs[WIDTH-1]) ? -div_bus.lhs : div_bus.lhs;
    rhs_abs   = (signed_en && div_bus.rhs[WIDTH-1]) ? -div_bus.rhs : div_bus.rhs;

    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          sel_rem_d = div_bus.sel_rem;
          q_neg_d   = signed_en && (div_bus.lhs[WIDTH-1] ^ div_bus.rhs[WIDTH-1]);
          r_neg_d   = signed_en && div_bus.lhs[WIDTH-1];
          dvd_d     = lhs_abs;
          dvs_d     = rhs_abs;
          rem_d     = '0;
          busy_d    = 1'b1;
          if (div_bus.rhs == '0) begin
            state_d = DIV_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            out_d   = div_bus.sel_rem ? div_bus.lhs : '1;
          end else begin
            state_d = DIV_RUN;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        dvd_d = q_next;
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          // MIN/-1 needs no special case: |MIN| is exact as unsigned and the
          // quotient sign cancels.
          if (sel_rem_q) out_d = r_neg_q ? -step_rem : step_rem;
          else           out_d = q_neg_q ? -q_next : q_next;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (div_bus.flush) begin
      state_d = DIV_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      out_d   = out_q;
      dz_d    = dz_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sel_rem_q <= sel_rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      out_q     <= out_d;
      dz_q      <= dz_d;
    end
  end

  // Stall drops in DONE so EX captures out on the edge that sees done.
  assign div_bus.stall = accept || (state_q == DIV_RUN);
  assign div_bus.busy  = busy_q;
  assign div_bus.done  = done_q;
  assign div_bus.out   = out_q;
  assign div_bus.dz    = dz_q;

  // The issuing pipeline is stalled during RUN, so a start here is a protocol error.
  a_no_start_in_run: assert property (
    @(posedge clk) disable iff (rst) !(state_q == DIV_RUN && div_bus.start)
  );

endmodule

// File: tb/tb_yutorina_div_ctrl.sv
// Scoreboard bench for the divide sequencer: expected results are queued
// at issue time and popped when done is seen.
module tb_yutorina_div_ctrl;

  logic clk;
  logic rst;

  yutorina_div_ctrl_if #(.WIDTH(32)) bus ();

  yutorina_div_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  typedef struct {
    logic [31:0] out;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn, input bit rem);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (!sgn) return rem ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
    return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        input bit rem, input logic [31:0] exp_out, input logic exp_dz,
                        input int exp_lat, input bit poke_done);
    exp_t e;
    bit   seen;
    bit   prof_bad;
    int   k;
    exp_q.push_back('{out: exp_out, dz: exp_dz, lat: exp_lat});
    @(negedge clk);
    bus.start = 1'b1; bus.sign_ = ~sgn; bus.sel_rem = rem; bus.lhs = a; bus.rhs = b;
    #1;
    checks++;
    if (bus.stall !== 1'b1) $display("FAIL stall_at_start: got %b want 1", bus.stall);
    else passed++;
    seen = 0; prof_bad = 0; k = 0;
    while (!seen && k < 60) begin
      k++;
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      @(negedge clk);
      if (bus.stall !== (k < exp_lat)) prof_bad = 1;
      if (bus.busy !== 1'b1) prof_bad = 1;
      if (bus.done === 1'b1) begin
        seen = 1;
        e = exp_q.pop_front();
        checks++;
        if (bus.out !== e.out) $display("FAIL out %h/%h: got %h want %h", a, b, bus.out, e.out);
        else passed++;
        checks++;
        if (bus.dz !== e.dz) $display("FAIL dz %h/%h: got %b want %b", a, b, bus.dz, e.dz);
        else passed++;
        checks++;
        if (k != e.lat) $display("FAIL latency %h/%h: got %0d want %0d", a, b, k, e.lat);
        else passed++;
      end
    end
    checks++;
    if (!seen) begin
      $display("FAIL done_timeout %h/%h: got no done want done at %0d", a, b, exp_lat);
      void'(exp_q.pop_front());
    end else passed++;
    checks++;
    if (prof_bad) $display("FAIL stall_busy_profile %h/%h: got bad profile want stall<%0d busy=1", a, b, exp_lat);
    else passed++;
    if (poke_done) begin
      bus.start = 1'b1; bus.lhs = 32'd1; bus.rhs = 32'd1;
      #1;
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL stall_in_done: got %b want 0", bus.stall);
      else passed++;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL idle_after_done: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    else passed++;
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    bit bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL %s: got done/busy activity want none", name);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.stall} !== 4'b0000 || bus.out !== 32'h0)
      $display("FAIL reset_state: got busy=%b done=%b dz=%b stall=%b out=%h want all 0",
               bus.busy, bus.done, bus.dz, bus.stall, bus.out);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 0, 0, 32'd14, 1'b0, 33, 0);
    run_op(32'd100, 32'd7, 0, 1, 32'd2,  1'b0, 33, 0);
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFF9, 32'd2, 1, 0, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1, 0, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1, 1, 32'd1,         1'b0, 33, 0);
  endtask

  task automatic test_div_zero();
    run_op(32'd5, 32'd0, 0, 0, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op(32'd5, 32'd0, 0, 1, 32'd5,         1'b1, 1, 0);
  endtask

  task automatic test_overflow();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 1'b0, 33, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0,         1'b0, 33, 0);
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.start = 1'b1; bus.sign_ = 1'b1; bus.sel_rem = 1'b0; bus.lhs = 32'd100; bus.rhs = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (k == 10) bus.flush = 1'b1;
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.stall} !== 3'b000)
      $display("FAIL flush_idle: got busy=%b done=%b stall=%b want 0 0 0", bus.busy, bus.done, bus.stall);
    else passed++;
    run_op(32'd20, 32'd3, 0, 0, 32'd6, 1'b0, 33, 0);
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk);
    bus.start = 1'b1; bus.sign_ = 1'b1; bus.sel_rem = 1'b0; bus.lhs = 32'd20; bus.rhs = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.stall} !== 4'b0000 || bus.out !== 32'h0)
      $display("FAIL rst_mid_run: got busy=%b done=%b dz=%b stall=%b out=%h want all 0",
               bus.busy, bus.done, bus.dz, bus.stall, bus.out);
    else passed++;
    expect_no_done("no_done_after_rst", 40);
  endtask

  task automatic test_start_flush();
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.lhs = 32'd9; bus.rhs = 32'd3;
    #1;
    checks++;
    if (bus.stall !== 1'b0) $display("FAIL start_flush_stall: got %b want 0", bus.stall);
    else passed++;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    expect_no_done("start_flush_ignored", 40);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    bit          sgn, rem;
    run_op(32'd1000, 32'd10, 0, 0, 32'd100, 1'b0, 33, 1);
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = (i % 3 == 0) ? $urandom : $urandom_range(1, 1000);
      sgn = (i % 2 == 1);
      rem = (i % 4 >= 2);
      run_op(a, b, sgn, rem, model_div(a, b, sgn, rem), 1'b0, 33, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.sign_ = 1'b1; bus.sel_rem = 1'b0;
    bus.lhs = '0; bus.rhs = '0; bus.flush = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_rst_mid_run();
    test_overflow();
    test_flush();
    test_start_flush();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
